// File: rtl/bullet_hit_detector.sv
// bullet_hit_detector: collision receiver for the bullet stream.
// Registers a box-overlap test between the active bullet and the player sprite, then runs a
// hit-hold / invulnerability / death FSM that tracks player HP.
//
// Ports:
//   CLOCK_50         system clock
//   reset            synchronous active-high reset
//   enable           detection/timer enable; 0 freezes the block
//   bullet_x/y       bullet top-left corner, pixels
//   bullet_active    bullet currently on screen
//   player_x/y       player top-left corner, pixels
//   player_collision high while a hit is being held and while dead
//   hit_pulse        one-cycle strobe per registered hit
//   hp               remaining HP
//   invulnerable     high during the post-hit invulnerability window
//   game_over        sticky, high once HP reaches 0
module bullet_hit_detector #(
  parameter int unsigned BULLET_W      = 4,
  parameter int unsigned BULLET_H      = 2,
  parameter int unsigned PLAYER_W      = 8,
  parameter int unsigned PLAYER_H      = 8,
  parameter int unsigned MAX_HP        = 5,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned INVULN_CYCLES = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic       bullet_active,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic       player_collision,
  output logic       hit_pulse,
  output logic [3:0] hp,
  output logic       invulnerable,
  output logic       game_over
);

  localparam logic [1:0] StArmed  = 2'd0;
  localparam logic [1:0] StHit    = 2'd1;
  localparam logic [1:0] StInvuln = 2'd2;
  localparam logic [1:0] StDead   = 2'd3;

  localparam logic [25:0] HoldInit   = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] InvulnInit = 26'(INVULN_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [3:0]  hp_q, hp_d;
  logic        overlap_q, overlap_d;
  logic        pulse_q, pulse_d;
  logic        ovx, ovy;

  // Widened by one bit so the right/bottom edges never wrap; touching edges do not overlap.
  assign ovx = (({1'b0, bullet_x} + 9'(BULLET_W)) > {1'b0, player_x}) &&
               (({1'b0, player_x} + 9'(PLAYER_W)) > {1'b0, bullet_x});
  assign ovy = (({1'b0, bullet_y} + 8'(BULLET_H)) > {1'b0, player_y}) &&
               (({1'b0, player_y} + 8'(PLAYER_H)) > {1'b0, bullet_y});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    pulse_d   = 1'b0;
    overlap_d = enable & bullet_active & ovx & ovy;
    if (enable) begin
      case (state_q)
        StArmed: begin
          if (overlap_q) begin
            state_d = StHit;
            hp_d    = (hp_q == 4'd0) ? 4'd0 : hp_q - 4'd1;
            pulse_d = 1'b1;
            cnt_d   = HoldInit;
          end
        end
        StHit: begin
          if (cnt_q == 26'd0) begin
            // hp_q was already decremented on entry, so 0 here means the last life is gone.
            if (hp_q == 4'd0) begin
              state_d = StDead;
            end else begin
              state_d = StInvuln;
              cnt_d   = InvulnInit;
            end
          end else begin
            cnt_d = cnt_q - 26'd1;
          end
        end
        StInvuln: begin
          if (cnt_q == 26'd0) begin
            state_d = StArmed;
          end else begin
            cnt_d = cnt_q - 26'd1;
          end
        end
        default: ;  // StDead is sticky until reset
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StArmed;
      cnt_q     <= 26'd0;
      hp_q      <= 4'(MAX_HP);
      overlap_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      overlap_q <= overlap_d;
      pulse_q   <= pulse_d;
    end
  end

  assign player_collision = (state_q == StHit) || (state_q == StDead);
  assign invulnerable     = (state_q == StInvuln);
  assign game_over        = (state_q == StDead);
  assign hit_pulse        = pulse_q;
  assign hp               = hp_q;

endmodule

// File: tb/tb_bullet_hit_detector.sv
module tb_bullet_hit_detector;

  localparam int Hold   = 4;
  localparam int Invuln = 20;
  localparam int MaxHp  = 5;

  logic       clk = 1'b0;
  logic       reset, enable, bullet_active;
  logic [7:0] bullet_x, player_x;
  logic [6:0] bullet_y, player_y;
  logic       player_collision, hit_pulse, invulnerable, game_over;
  logic [3:0] hp;

  int total = 0;
  int bad   = 0;

  bullet_hit_detector #(
    .HOLD_CYCLES  (Hold),
    .INVULN_CYCLES(Invuln)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .enable          (enable),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .bullet_active   (bullet_active),
    .player_x        (player_x),
    .player_y        (player_y),
    .player_collision(player_collision),
    .hit_pulse       (hit_pulse),
    .hp              (hp),
    .invulnerable    (invulnerable),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  // Reference model: time since the last hit, counted in enabled cycles.
  int m_hp    = MaxHp;
  bit m_ovq   = 0;
  bit m_dead  = 0;
  bit m_win   = 0;
  int m_e     = 0;
  bit m_pulse = 0;

  // Observation counters for the directed scenarios.
  int n_pulse = 0;
  int n_coll  = 0;
  int n_inv   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit boxes_overlap(input int bx, input int by, input int px, input int py);
    return (bx + 4 > px) && (px + 8 > bx) && (by + 2 > py) && (py + 8 > by);
  endfunction

  task automatic step(input bit r, input bit en, input bit ba,
                      input int bx, input int by, input int px, input int py);
    bit ov_now;
    reset = r; enable = en; bullet_active = ba;
    bullet_x = 8'(bx); bullet_y = 7'(by); player_x = 8'(px); player_y = 7'(py);
    ov_now = en && ba && boxes_overlap(bx, by, px, py);
    @(posedge clk);
    #1;
    if (r) begin
      m_hp = MaxHp; m_ovq = 0; m_dead = 0; m_win = 0; m_e = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (!m_dead && en) begin
        if (m_win) begin
          m_e++;
          if (m_e == Hold && m_hp == 0) begin
            m_dead = 1; m_win = 0;
          end else if (m_e == Hold + Invuln) begin
            m_win = 0;
          end
        end else if (m_ovq) begin
          m_hp    = (m_hp > 0) ? m_hp - 1 : 0;
          m_pulse = 1;
          m_win   = 1;
          m_e     = 0;
        end
      end
      m_ovq = ov_now;
    end
    check_eq("hp", 32'(hp), 32'(m_hp));
    check_eq("hit_pulse", 32'(hit_pulse), 32'(m_pulse));
    check_eq("collision", 32'(player_collision), 32'(m_dead || (m_win && m_e < Hold)));
    check_eq("invulnerable", 32'(invulnerable), 32'(m_win && m_e >= Hold));
    check_eq("game_over", 32'(game_over), 32'(m_dead));
    n_pulse += 32'(hit_pulse);
    n_coll  += 32'(player_collision);
    n_inv   += 32'(invulnerable);
  endtask

  task automatic clear_counts();
    n_pulse = 0; n_coll = 0; n_inv = 0;
  endtask

  initial begin
    int first;
    int p1, p2, p3;
    int inv_between;
    bit inv_seen;
    int dis;

    // 1: reset held two cycles
    step(1, 1, 0, 0, 0, 76, 68);
    step(1, 1, 0, 0, 0, 76, 68);
    step(0, 1, 0, 0, 0, 76, 68);
    check_eq("t1_hp", 32'(hp), 5);
    check_eq("t1_outs", 32'({player_collision, hit_pulse, invulnerable, game_over}), 0);

    // 2: touching edge then a one-pixel overlap
    clear_counts();
    for (int i = 0; i < 10; i++) step(0, 1, 1, 72, 71, 76, 68);
    check_eq("t2_touch_pulses", 32'(n_pulse), 0);
    clear_counts();
    first = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) step(0, 1, 1, 73, 71, 76, 68);
      else        step(0, 1, 1, 72, 71, 76, 68);
      if (hit_pulse && first < 0) first = i;
    end
    check_eq("t2_latency", 32'(first), 1);
    check_eq("t2_pulses", 32'(n_pulse), 1);
    check_eq("t2_coll_cycles", 32'(n_coll), Hold);
    check_eq("t2_hp", 32'(hp), 4);

    // 3: overlapping position but bullet inactive
    step(1, 1, 0, 0, 0, 76, 68);
    clear_counts();
    for (int i = 0; i < 100; i++) step(0, 1, 0, 80, 71, 76, 68);
    check_eq("t3_pulses", 32'(n_pulse), 0);
    check_eq("t3_hp", 32'(hp), 5);

    // 4: continuous overlap, hits spaced Hold+Invuln+1
    step(1, 1, 0, 0, 0, 76, 68);
    p1 = -1; p2 = -1; p3 = -1; inv_between = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 1, 80, 71, 76, 68);
      if (hit_pulse) begin
        if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i; else if (p3 < 0) p3 = i;
      end
      if (p1 >= 0 && p2 < 0 && invulnerable) inv_between++;
    end
    check_eq("t4_spacing12", 32'(p2 - p1), Hold + Invuln + 1);
    check_eq("t4_spacing23", 32'(p3 - p2), Hold + Invuln + 1);
    check_eq("t4_inv_window", 32'(inv_between), Invuln);
    check_eq("t4_hp", 32'(hp), 2);

    // 5: keep overlapping until dead, then recover via reset
    clear_counts();
    for (int i = 0; i < 250; i++) step(0, 1, 1, 80, 71, 76, 68);
    check_eq("t5_more_hits", 32'(n_pulse), 2);
    check_eq("t5_hp", 32'(hp), 0);
    check_eq("t5_game_over", 32'(game_over), 1);
    check_eq("t5_collision", 32'(player_collision), 1);
    step(0, 0, 1, 80, 71, 76, 68);
    check_eq("t5_dead_disabled", 32'(game_over), 1);
    step(1, 1, 1, 80, 71, 76, 68);
    check_eq("t5_reset_hp", 32'(hp), 5);
    check_eq("t5_reset_go", 32'(game_over), 0);

    // 6a: enable low for 10 cycles inside the invulnerability window
    step(1, 1, 0, 0, 0, 76, 68);
    clear_counts();
    inv_seen = 0; dis = 0;
    for (int i = 0; i < 70; i++) begin
      if (i == 0) begin
        step(0, 1, 1, 80, 71, 76, 68);
      end else if (inv_seen && dis < 10) begin
        dis++;
        step(0, 0, 1, 10, 10, 76, 68);
        check_eq("t6_inv_frozen", 32'(invulnerable), 1);
      end else begin
        step(0, 1, 1, 10, 10, 76, 68);
      end
      if (invulnerable) inv_seen = 1;
    end
    check_eq("t6_inv_total", 32'(n_inv), Invuln + 10);
    check_eq("t6_hp", 32'(hp), 4);

    // 6b: overlapping bullet with enable low
    step(1, 1, 0, 0, 0, 76, 68);
    clear_counts();
    for (int i = 0; i < 10; i++) step(0, 0, 1, 80, 71, 76, 68);
    check_eq("t6_dis_pulses", 32'(n_pulse), 0);
    check_eq("t6_dis_hp", 32'(hp), 5);

    // Random traffic around the player, with occasional resets
    step(1, 1, 0, 0, 0, 76, 68);
    for (int i = 0; i < 4000; i++) begin
      int px, py;
      px = 20 + int'($urandom_range(0, 200));
      py = 10 + int'($urandom_range(0, 100));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 3) != 0,
           px - 6 + int'($urandom_range(0, 16)), py - 4 + int'($urandom_range(0, 12)), px, py);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_hit_detector.md
Name: bullet_hit_detector

Overview:
- Receiving end of the bullet interface. Consumes the bullet stream (`bullet_x`, `bullet_y`, `bullet_active`) and the player sprite position.
- Detects box overlap between bullet and player, tracks player HP, and enforces a hit-hold window followed by an invulnerability window.
- Drives `player_collision` back to the bullet generators, which freeze and clear their bullets while it is high.
- Sits between the bullet generators, the player controller and the HUD/game FSM.

Parameters:
BULLET_W, 4, bullet box width in pixels (1..15)
BULLET_H, 2, bullet box height in pixels (1..15)
PLAYER_W, 8, player box width in pixels (1..15)
PLAYER_H, 8, player box height in pixels (1..15)
MAX_HP, 5, HP loaded at reset (1..15)
HOLD_CYCLES, 4, cycles `player_collision` is held per hit (>=1)
INVULN_CYCLES, 50_000_000, invulnerability length in cycles, 1 s at 50 MHz (>=1, fits 26 bits)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  detection/timer enable; 0 freezes the block
bullet_x  in  8  bullet left edge, pixels
bullet_y  in  7  bullet top edge, pixels
bullet_active  in  1  bullet currently on screen
player_x  in  8  player left edge
player_y  in  7  player top edge
player_collision  out  1  high during hit-hold and while dead
hit_pulse  out  1  one-cycle strobe per registered hit
hp  out  4  remaining HP
invulnerable  out  1  high in INVULN state
game_over  out  1  sticky, high when HP reaches 0

Behaviour:
- Reset (sync, `reset`=1 at a CLOCK_50 edge): state=ARMED, hp=MAX_HP, overlap_q=0, counter=0, all 1-bit outputs 0. Reset has priority over everything, mid-operation included.
- Stage 1 (registered each edge):
  - overlap_q <= enable & bullet_active & ovx & ovy.
  - ovx = (bullet_x+BULLET_W > player_x) & (player_x+PLAYER_W > bullet_x), computed at 9 bits, no wrap.
  - ovy is the same with BULLET_H/PLAYER_H, computed at 8 bits.
  - Touching edges (e.g. bullet_x+BULLET_W == player_x) is not an overlap.
- Latency: inputs sampled at edge N give overlap_q at N+1. FSM reacts at N+2, so `player_collision`/`hit_pulse` are visible 2 cycles after the inputs.
- enable=0:
  - overlap_q forced 0.
  - FSM state, counter, hp and outputs hold, except hit_pulse, which is 0.
  - enable=0 beats a pending overlap_q in the same cycle.
- FSM (`player_collision` is registered, high in HIT and DEAD):
  - ARMED: if overlap_q → HIT; hp <= hp-1, saturating at 0; hit_pulse=1 for that one cycle; counter <= HOLD_CYCLES-1.
  - HIT: counter decrements each enabled cycle. At counter==0: if hp==0 → DEAD, else → INVULN with counter <= INVULN_CYCLES-1.
  - INVULN: invulnerable=1; overlaps are ignored and not queued; counter decrements each enabled cycle; at 0 → ARMED.
  - DEAD: game_over=1, player_collision=1, hp=0. Sticky until reset; overlaps and enable are ignored.
- A continuous overlap produces exactly one hit per HOLD_CYCLES+INVULN_CYCLES+1 cycles.
- hit_pulse is never high for two consecutive cycles. hp never underflows and never exceeds MAX_HP.
- hp changes only on the ARMED→HIT transition.

Test Plan:
1. Reset held 2 cycles, then released → hp=5; player_collision, hit_pulse, invulnerable, game_over all 0.
2. Player (76,68), bullet (72,71) active, enable=1 → no hit ever. Change to bullet (73,71) at edge N → hit_pulse=1 exactly in the cycle after edge N+2; player_collision high 4 cycles; hp=4.
3. Bullet (80,71), bullet_active=0, held 100 cycles → no hit, hp stays 5.
4. Override HOLD_CYCLES=4, INVULN_CYCLES=20; hold overlap continuously → hit_pulse every 25 cycles; invulnerable high 20 cycles between hits; hp 5→4→3.
5. Same overrides, overlap held → after 5th hit hp=0, game_over=1, player_collision stays 1 for 200 more cycles; assert reset → hp=5, game_over=0, state ARMED.
6. Hit, then enable=0 for 10 cycles mid-INVULN → invulnerable stays 1 and window extends by 10 cycles. Separately, overlapping bullet with enable=0 → no hit_pulse and hp unchanged.
